fft16_frame_ctrl: RTL and testbench

FFT16_FRAME_CTRL -- requirements
Module: fft16_frame_ctrl

---
 rtl/fft16_pkg.sv | 22 ++
 rtl/fft16_unload_seq.sv | 69 ++++++
 rtl/fft16_frame_ctrl.sv | 99 +++++++++
 tb/tb_fft16_frame_ctrl.sv | 139 +++++++++++++
 4 files changed

// File: rtl/fft16_pkg.sv
// Shared constants, count type and state encodings for the FFT16 frame controller.
package fft16_pkg;

    localparam int NPT = 16;

    typedef logic [3:0] cnt_t;

    localparam cnt_t CNT_LAST = cnt_t'(NPT - 1);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        WAIT,
        FIRE
    } in_state_t;

    typedef enum logic {
        OIDLE,
        UNLOAD
    } out_state_t;

endpackage

// File: rtl/fft16_unload_seq.sv
// Output sequencer: walks bins 0..15 after each FIRE strobe from the input side.
module fft16_unload_seq
    import fft16_pkg::cnt_t;
    import fft16_pkg::CNT_LAST;
    import fft16_pkg::out_state_t;
    import fft16_pkg::OIDLE;
    import fft16_pkg::UNLOAD;
(
    input  logic       CLK,
    input  logic       RESET,
    input  logic       FIRE,
    output logic       OUT_VALID,
    output logic [3:0] OUT_IDX,
    output logic       DONE
);

    out_state_t state, state_n;
    cnt_t       idx, idx_n;
    logic       done_q;

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state  <= OIDLE;
            idx    <= '0;
            done_q <= 1'b0;
        end else begin
            state  <= state_n;
            idx    <= idx_n;
            done_q <= (state_n == UNLOAD) && (idx_n == CNT_LAST);
        end
    end

    always_comb begin
        state_n = state;
        idx_n   = '0;
        case (state)
            OIDLE: begin
                if (FIRE) begin
                    state_n = UNLOAD;
                    idx_n   = '0;
                end
            end
            UNLOAD: begin
                if (idx == CNT_LAST) begin
                    state_n = OIDLE;
                    idx_n   = '0;
                end else begin
                    idx_n = idx + 4'd1;
                end
            end
            default: begin
                state_n = OIDLE;
                idx_n   = '0;
            end
        endcase
    end

    // The input sequencer cannot fire again before an unload completes.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            assert (!(FIRE && (state == UNLOAD)));
        end
    end

    assign OUT_VALID = (state == UNLOAD);
    assign OUT_IDX   = idx;
    assign DONE      = done_q;

endmodule

// File: rtl/fft16_frame_ctrl.sv
// FFT16 frame controller: input load/wait/fire sequencer feeding the unload sequencer.
module fft16_frame_ctrl
    import fft16_pkg::*;
#(
    parameter int PIPE_LAT = 4,
    parameter int NPT      = 16
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       START,
    output logic       SEL,
    output logic       OUT_VALID,
    output logic [3:0] OUT_IDX,
    output logic       DONE,
    output logic       BUSY,
    output logic       OVERRUN
);

    localparam cnt_t LOAD_LAST = cnt_t'(NPT - 1);
    localparam cnt_t WAIT_LAST = cnt_t'(PIPE_LAT);

    in_state_t state, state_n;
    cnt_t      cnt, cnt_n;
    logic      ovr_n;
    logic      sel_q, busy_q, ovr_q;

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state  <= IDLE;
            cnt    <= '0;
            sel_q  <= 1'b0;
            busy_q <= 1'b0;
            ovr_q  <= 1'b0;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            sel_q  <= (state_n == FIRE);
            busy_q <= (state_n != IDLE);
            ovr_q  <= ovr_n;
        end
    end

    // Sample 0 arrives with START, so LOAD counts the remaining samples 1..15.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        ovr_n   = 1'b0;
        case (state)
            IDLE: begin
                cnt_n = '0;
                if (START) begin
                    state_n = LOAD;
                    cnt_n   = 4'd1;
                end
            end
            LOAD: begin
                if (cnt == LOAD_LAST) begin
                    state_n = (PIPE_LAT == 0) ? FIRE : WAIT;
                    cnt_n   = 4'd1;
                end else begin
                    cnt_n = cnt + 4'd1;
                end
            end
            WAIT: begin
                if (cnt == WAIT_LAST) begin
                    state_n = FIRE;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + 4'd1;
                end
            end
            FIRE: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
        endcase
        if (START && (state != IDLE)) begin
            ovr_n = 1'b1;
        end
    end

    fft16_unload_seq u_unload (
        .CLK       (CLK),
        .RESET     (RESET),
        .FIRE      (sel_q),
        .OUT_VALID (OUT_VALID),
        .OUT_IDX   (OUT_IDX),
        .DONE      (DONE)
    );

    assign SEL     = sel_q;
    assign BUSY    = busy_q;
    assign OVERRUN = ovr_q;

endmodule

// File: tb/tb_fft16_frame_ctrl.sv
// Self-checking bench: two controller instances (PIPE_LAT 4 and 0) against a timeline model.
module tb_fft16_frame_ctrl;

    logic       CLK = 1'b0;
    logic       RESET;
    logic       START;

    logic       sel0, valid0, done0, busy0, ovr0;
    logic [3:0] idx0;
    logic       sel1, valid1, done1, busy1, ovr1;
    logic [3:0] idx1;

    int checks = 0;
    int fails  = 0;
    int cyc    = 0;
    bit armed  = 1'b0;

    // Model state per instance: accepted START cycle, last FIRE cycle, pending overrun.
    int acc [2] = '{-1, -1};
    int fir [2] = '{-1, -1};
    bit ovr [2] = '{1'b0, 1'b0};
    int pl  [2] = '{4, 0};

    always #5 CLK = ~CLK;

    fft16_frame_ctrl #(.PIPE_LAT(4), .NPT(16)) dut0 (
        .CLK(CLK), .RESET(RESET), .START(START),
        .SEL(sel0), .OUT_VALID(valid0), .OUT_IDX(idx0),
        .DONE(done0), .BUSY(busy0), .OVERRUN(ovr0)
    );

    fft16_frame_ctrl #(.PIPE_LAT(0), .NPT(16)) dut1 (
        .CLK(CLK), .RESET(RESET), .START(START),
        .SEL(sel1), .OUT_VALID(valid1), .OUT_IDX(idx1),
        .DONE(done1), .BUSY(busy1), .OVERRUN(ovr1)
    );

    function automatic bit m_busy(int k, int c);
        return (acc[k] >= 0) && (c > acc[k]) && (c <= acc[k] + 16 + pl[k]);
    endfunction

    function automatic bit m_sel(int k, int c);
        return (acc[k] >= 0) && (c == acc[k] + 16 + pl[k]);
    endfunction

    // Packed as {SEL, BUSY, OVERRUN, OUT_VALID, OUT_IDX[3:0], DONE}.
    function automatic logic [8:0] m_out(int k, int c);
        bit         v;
        int         i;
        logic [3:0] i4;
        v  = (fir[k] >= 0) && (c > fir[k]) && (c <= fir[k] + 16);
        i  = v ? (c - fir[k] - 1) : 0;
        i4 = i[3:0];
        return {m_sel(k, c), m_busy(k, c), ovr[k], v, i4, (v && i == 15)};
    endfunction

    task automatic m_update(int k, int c, logic st, logic rst);
        if (!rst) begin
            acc[k] = -1;
            fir[k] = -1;
            ovr[k] = 1'b0;
        end else begin
            bit b;
            b = m_busy(k, c);
            if (m_sel(k, c)) fir[k] = c;
            ovr[k] = 1'b0;
            if (st) begin
                if (b) ovr[k] = 1'b1;
                else   acc[k] = c;
            end
        end
    endtask

    task automatic step(input logic st, input logic rst);
        logic [8:0] e0, e1, o0, o1;
        START = st;
        RESET = rst;
        @(negedge CLK);
        if (armed) begin
            e0 = m_out(0, cyc);
            e1 = m_out(1, cyc);
            o0 = {sel0, busy0, ovr0, valid0, idx0, done0};
            o1 = {sel1, busy1, ovr1, valid1, idx1, done1};
            checks++;
            assert (o0 === e0) else begin
                fails++;
                $error("FAIL lat4_outputs cycle %0d: observed %b expected %b (sel,busy,ovr,valid,idx,done)", cyc, o0, e0);
            end
            checks++;
            assert (o1 === e1) else begin
                fails++;
                $error("FAIL lat0_outputs cycle %0d: observed %b expected %b (sel,busy,ovr,valid,idx,done)", cyc, o1, e1);
            end
        end
        m_update(0, cyc, st, rst);
        m_update(1, cyc, st, rst);
        if (!rst) armed = 1'b1;
        @(posedge CLK);
        #1;
        cyc++;
    endtask

    // One reset cycle, then len cycles with local cycle numbering starting at 0.
    task automatic scen(input int len, input int s0, input int s1, input int r0);
        step(1'b0, 1'b0);
        for (int c = 0; c < len; c++) begin
            step((c == s0) || (c == s1), !(c == r0));
        end
    endtask

    initial begin
        START = 1'b0;
        RESET = 1'b0;
        @(posedge CLK);
        #1;
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);

        scen(60, 10, -1, -1);
        scen(80, 10, 31, -1);
        scen(50, 10, 15, -1);
        scen(60, 10, 25, 20);
        scen(50, 0, -1, -1);
        scen(60, 10, -1, 38);
        scen(60, 10, 26, -1);
        scen(60, 10, 30, -1);

        for (int n = 0; n < 3000; n++) begin
            step(($urandom_range(0, 7) == 0), ($urandom_range(0, 99) != 0));
        end
        for (int n = 0; n < 50; n++) begin
            step(1'b0, 1'b1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
